uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin arbiter and sequencer that shares one `UART_tx` instance among up to `NREQ` byte requesters (telemetry, command echo, debug). It captures the winning requester's byte, issues a single-cycle `trmt`, waits for `tx_done`, then returns a completion strobe to the owner. A per-requester lock keeps ownership across multi-byte packets. A watchdog recovers from a stalled transmitter.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 40000: max cycles from `trmt` to `tx_done` rise; 17-bit counter.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req`  in  NREQ  per-requester byte request; level.
- `req_lock`  in  NREQ  hold ownership for the next byte of the same packet.
- `req_data`  in  NREQ*8  byte of requester i at bits [8i+7:8i].
- `gnt`  out  NREQ  one-cycle pulse: byte of requester i captured.
- `done`  out  NREQ  one-cycle pulse: byte of requester i finished or aborted.
- `err`  out  1  one-cycle pulse on watchdog abort.
- `busy`  out  1  high in any state other than IDLE.
- `owner`  out  3  index of the current/last owner.
- `trmt`  out  1  to `UART_tx.trmt`; one-cycle pulse.
- `tx_data`  out  8  to `UART_tx.tx_data`; held stable from `trmt` until return to IDLE.
- `tx_done`  in  1  from `UART_tx.tx_done`; level or pulse accepted.

## Operation
- States: IDLE, XMIT, WAIT.
- IDLE: if `|req`, select winner; at that edge latch `tx_data`, `owner`; assert `gnt[winner]`, `trmt` (registered); go to XMIT.
- Winner: if `locked` and `req[owner]`, owner wins. Otherwise first set `req` bit scanning from `ptr` upward, wrapping modulo `NREQ`.
- `locked` := `req_lock[winner]`, sampled at grant. Cleared in IDLE when `req[owner]` is low.
- XMIT: single cycle; `trmt`/`gnt` drop; clear watchdog counter; go to WAIT.
- WAIT: detect rising edge `tx_done & ~tx_done_q`. A level `tx_done` still high from the previous byte is not an edge, so it never double-completes.
  - On edge: pulse `done[owner]`; `ptr` := `owner`+1 mod `NREQ`; go to IDLE.
  - If counter reaches `TIMEOUT` first: pulse `err` and `done[owner]`; `locked` := 0; advance `ptr`; go to IDLE.
- Requester contract:
  - Hold `req` and `req_data` stable until `gnt`.
  - After `gnt`, data may change.
  - Drop `req` before `done` if there are no more bytes.
  - `req` is sampled only in IDLE.
- Unlisted requester indices (≥ `NREQ`) do not exist; `owner` upper bits are 0.

## Timing
- Reset values: state IDLE; `gnt`, `done`, `err`, `trmt`, `busy` = 0; `tx_data` = 0; `owner` = 0; `ptr` = 0; `locked` = 0; `tx_done_q` = 0.
- `req` seen at edge k → `gnt` and `trmt` high in cycle k+1 → XMIT.
- `tx_done` rise sampled at edge m → `done` high in cycle m+1, state IDLE.
  - Next grant is no earlier than cycle m+2, one idle cycle minimum between bytes.
- Simultaneous requests at reset with `ptr`=0: grant order 0,1,2,3.
- `gnt` and `done` are never high for two different requesters in the same cycle.
- `req` changes during XMIT/WAIT are ignored until IDLE.
- Reset mid-WAIT: everything returns to reset values immediately. No `done` is issued; the requester re-requests.

## Test plan
- Single byte: `req[2]`=1, data 0x6A. Expect:
  - `gnt[2]` and `trmt` one cycle;
  - looped `UART_rcv` shows `rx_data` 0x6A;
  - `done[2]` one cycle after `tx_done` rise;
  - `busy` low afterwards.
- Contention: all four `req` high with data 0xA0..0xA3, held through each `done`. Expect receive order A0, A1, A2, A3, A0, each `gnt` exactly once per round.
- Lock burst:
  - Requester 1 sends 0x11, 0x22, 0x33 with `req_lock[1]`=1 while `req[0]` and `req[3]` stay high.
  - Expect 11, 22, 33 consecutive, then 3's byte, then 0's byte.
- Level `tx_done`: hold `tx_done` high after completion and re-request. Expect exactly one `done` per byte and no premature completion.
- Watchdog: `TIMEOUT`=100, `tx_done` tied low. Expect `err` and `done[owner]` at cycle 101 after XMIT, IDLE, next requester served.
- Reset mid-WAIT: assert `rst` half-way through a byte. Expect all outputs 0 asynchronously, `ptr`=0, no `done`; after release, `req[0]` and `req[1]` high grant requester 0 first.

Source files
------------

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one UART_tx among NREQ byte requesters
// Lock keeps ownership across a packet; watchdog aborts a stalled transmitter.
module uart_tx_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 40000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_lock,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic              busy,
  output logic [2:0]        owner,
  output logic              trmt,
  output logic [7:0]        tx_data,
  input  logic              tx_done
);

  typedef enum logic [1:0] {IDLE, XMIT, WAIT} state_t;

  state_t          state, state_nxt;
  logic [2:0]      ptr, win, idx, owner_inc;
  logic [3:0]      sum;
  logic            locked, tx_done_q, found;
  logic            do_grant, do_finish, do_abort;
  logic [16:0]     wd_cnt;
  logic [7:0]      req_x, lock_x;
  logic [63:0]     data_x;
  logic [NREQ-1:0] win_hot, own_hot;

  // Zero-extended views so a 3-bit index always matches the vector width
  assign req_x     = 8'(req);
  assign lock_x    = 8'(req_lock);
  assign data_x    = 64'(req_data);
  assign busy      = (state != IDLE);
  assign owner_inc = (owner == 3'(NREQ - 1)) ? 3'd0 : owner + 3'd1;

  always_comb begin
    win   = owner;
    found = 1'b0;
    idx   = 3'd0;
    sum   = 4'd0;
    if (locked && req_x[owner]) begin
      found = 1'b1;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        sum = {1'b0, ptr} + 4'(i);
        if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
        idx = sum[2:0];
        if (!found && req_x[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      win_hot[k] = (win == 3'(k));
      own_hot[k] = (owner == 3'(k));
    end
  end

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_finish = 1'b0;
    do_abort  = 1'b0;
    case (state)
      IDLE: if (found) begin
        do_grant  = 1'b1;
        state_nxt = XMIT;
      end
      XMIT: state_nxt = WAIT;
      WAIT: begin
        // Edge detect: a tx_done level left high by the previous byte is ignored
        if (tx_done && !tx_done_q) begin
          do_finish = 1'b1;
          state_nxt = IDLE;
        end else if (wd_cnt >= 17'(TIMEOUT - 1)) begin
          do_abort  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      trmt      <= 1'b0;
      tx_data   <= 8'd0;
      owner     <= 3'd0;
      ptr       <= 3'd0;
      locked    <= 1'b0;
      tx_done_q <= 1'b0;
      wd_cnt    <= 17'd0;
    end else begin
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      trmt      <= 1'b0;
      tx_done_q <= tx_done;
      if (state == IDLE && locked && !req_x[owner]) locked <= 1'b0;
      if (do_grant) begin
        gnt     <= win_hot;
        trmt    <= 1'b1;
        tx_data <= data_x[{win, 3'b000} +: 8];
        owner   <= win;
        locked  <= lock_x[win];
      end
      if (state == XMIT)      wd_cnt <= 17'd0;
      else if (state == WAIT) wd_cnt <= wd_cnt + 17'd1;
      if (do_finish || do_abort) begin
        done <= own_hot;
        ptr  <= owner_inc;
      end
      if (do_abort) begin
        err    <= 1'b1;
        locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - directed self-checking bench for uart_tx_arb
// The bench plays the UART_tx role: it captures tx_data at trmt and drives tx_done.
module tb_uart_tx_arb;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req, req_lock, gnt, done;
  logic [NREQ*8-1:0] req_data;
  logic              err, busy, trmt, tx_done;
  logic [2:0]        owner;
  logic [7:0]        tx_data;
  int                total = 0;
  int                bad   = 0;

  uart_tx_arb #(.NREQ(NREQ), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .req(req), .req_lock(req_lock), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .busy(busy), .owner(owner),
    .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req = '0; req_lock = '0; req_data = '0; tx_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Waits for trmt, records byte and gnt, completes the byte with a tx_done rise,
  // returns the done vector seen in the completion cycle.
  task automatic serve(input bit hold_level, output logic [7:0] b,
                       output logic [NREQ-1:0] g, output logic [NREQ-1:0] d, output bit ok);
    int n;
    ok = 1'b0; b = 8'd0; g = '0; d = '0; n = 0;
    while (trmt !== 1'b1 && n < 50) begin tick(); n++; end
    if (trmt !== 1'b1) return;
    b = tx_data; g = gnt;
    repeat (3) tick();
    tx_done = 1'b1;
    tick();
    d = done;
    if (!hold_level) tx_done = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    total++;
    if ({gnt, done, err, busy, trmt} !== 11'd0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0", {gnt, done, err, busy, trmt});
    end
    total++;
    if ({owner, tx_data} !== 11'd0) begin
      bad++; $display("FAIL reset_data: got owner=%0d tx_data=%h want 0/00", owner, tx_data);
    end
  endtask

  task automatic test_single;
    do_reset();
    req_data[23:16] = 8'h6A; req = 4'b0100;
    tick();
    total++;
    if ({gnt, trmt, tx_data, owner, busy} !== {4'b0100, 1'b1, 8'h6A, 3'd2, 1'b1}) begin
      bad++; $display("FAIL single_grant: got gnt=%b trmt=%b data=%h owner=%0d busy=%b want 0100 1 6a 2 1",
                      gnt, trmt, tx_data, owner, busy);
    end
    tick();
    req = 4'b0000;
    total++;
    if ({gnt, trmt, busy} !== {4'b0000, 1'b0, 1'b1}) begin
      bad++; $display("FAIL single_xmit: got gnt=%b trmt=%b busy=%b want 0000 0 1", gnt, trmt, busy);
    end
    tick(); tick();
    tx_done = 1'b1;
    tick();
    total++;
    if ({done, busy, tx_data} !== {4'b0100, 1'b0, 8'h6A}) begin
      bad++; $display("FAIL single_done: got done=%b busy=%b data=%h want 0100 0 6a", done, busy, tx_data);
    end
    tx_done = 1'b0;
    tick();
    total++;
    if ({done, busy, trmt} !== 6'd0) begin
      bad++; $display("FAIL single_after: got done=%b busy=%b trmt=%b want 0", done, busy, trmt);
    end
  endtask

  task automatic test_contention;
    logic [7:0] b; logic [NREQ-1:0] g, d; bit ok;
    logic [NREQ-1:0] exp_hot;
    do_reset();
    req_data = 32'hA3A2A1A0; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve(1'b0, b, g, d, ok);
      exp_hot = 4'b0001 << (i % 4);
      total++;
      if (!ok || b !== 8'hA0 + 8'(i % 4)) begin
        bad++; $display("FAIL contention_byte%0d: got %h ok=%0d want %h", i, b, ok, 8'hA0 + 8'(i % 4));
      end
      total++;
      if (g !== exp_hot || d !== exp_hot) begin
        bad++; $display("FAIL contention_hs%0d: got gnt=%b done=%b want %b", i, g, d, exp_hot);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_lock_burst;
    logic [7:0] b; logic [NREQ-1:0] g, d; bit ok;
    logic [7:0] exp_b [5];
    logic [7:0] got_b [5];
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'hB3; exp_b[4] = 8'hB0;
    do_reset();
    req_data[7:0] = 8'hB0; req = 4'b0001;
    serve(1'b0, b, g, d, ok);
    total++;
    if (!ok || b !== 8'hB0) begin
      bad++; $display("FAIL lock_prime: got %h want b0", b);
    end
    req_data = {8'hB3, 8'h00, 8'h11, 8'hB0}; req = 4'b1011; req_lock = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      serve(1'b0, b, g, d, ok);
      got_b[i] = ok ? b : 8'hxx;
      if (i == 0) req_data[15:8] = 8'h22;
      if (i == 1) req_data[15:8] = 8'h33;
      if (i == 2) begin req[1] = 1'b0; req_lock = '0; end
      if (i == 3) req[3] = 1'b0;
    end
    req = '0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (got_b[i] !== exp_b[i]) begin
        bad++; $display("FAIL lock_order%0d: got %h want %h", i, got_b[i], exp_b[i]);
      end
    end
    tick();
  endtask

  task automatic test_level_done;
    logic [7:0] b; logic [NREQ-1:0] g, d; bit ok;
    int dcount;
    do_reset();
    req_data[23:16] = 8'h5C; req = 4'b0100;
    serve(1'b1, b, g, d, ok);
    total++;
    if (!ok || b !== 8'h5C || d !== 4'b0100) begin
      bad++; $display("FAIL level_first: got %h done=%b want 5c 0100", b, d);
    end
    req_data[23:16] = 8'h5D;
    tick();
    total++;
    if (trmt !== 1'b1 || tx_data !== 8'h5D) begin
      bad++; $display("FAIL level_regrant: got trmt=%b data=%h want 1 5d", trmt, tx_data);
    end
    req = '0;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done !== 4'b0000) dcount++;
    end
    total++;
    if (dcount !== 0 || busy !== 1'b1) begin
      bad++; $display("FAIL level_premature: got dones=%0d busy=%b want 0 1", dcount, busy);
    end
    tx_done = 1'b0;
    tick();
    tx_done = 1'b1;
    tick();
    total++;
    if (done !== 4'b0100) begin
      bad++; $display("FAIL level_second: got %b want 0100", done);
    end
    tick();
    total++;
    if (done !== 4'b0000) begin
      bad++; $display("FAIL level_single_pulse: got %b want 0000", done);
    end
    tx_done = 1'b0;
    tick();
  endtask

  task automatic test_watchdog;
    logic [7:0] b; logic [NREQ-1:0] g, d; bit ok;
    int n;
    do_reset();
    req_data[15:8] = 8'h77; req_data[23:16] = 8'h88; req = 4'b0110;
    n = 0;
    while (trmt !== 1'b1 && n < 10) begin tick(); n++; end
    total++;
    if (trmt !== 1'b1 || owner !== 3'd1) begin
      bad++; $display("FAIL wd_grant: got trmt=%b owner=%0d want 1 1", trmt, owner);
    end
    req[1] = 1'b0;
    n = 0;
    while (err !== 1'b1 && n < 200) begin tick(); n++; end
    total++;
    if (err !== 1'b1 || n !== 101) begin
      bad++; $display("FAIL wd_latency: got err=%b after %0d cycles want 1 after 101", err, n);
    end
    total++;
    if (done !== 4'b0010 || busy !== 1'b0) begin
      bad++; $display("FAIL wd_done: got done=%b busy=%b want 0010 0", done, busy);
    end
    serve(1'b0, b, g, d, ok);
    total++;
    if (!ok || b !== 8'h88 || g !== 4'b0100 || d !== 4'b0100) begin
      bad++; $display("FAIL wd_next: got %h gnt=%b done=%b want 88 0100 0100", b, g, d);
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid_wait;
    logic [7:0] b; logic [NREQ-1:0] g, d; bit ok;
    int n, dcount;
    do_reset();
    req_data = {8'h93, 8'h00, 8'h21, 8'h10}; req = 4'b0001;
    serve(1'b0, b, g, d, ok);
    req = 4'b1000;
    n = 0;
    while (trmt !== 1'b1 && n < 10) begin tick(); n++; end
    req = '0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({gnt, done, err, busy, trmt, owner, tx_data} !== 22'd0) begin
      bad++; $display("FAIL rst_async: got gnt=%b done=%b err=%b busy=%b trmt=%b owner=%0d data=%h want 0",
                      gnt, done, err, busy, trmt, owner, tx_data);
    end
    dcount = 0;
    tx_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done !== 4'b0000) dcount++;
    end
    tx_done = 1'b0;
    rst = 1'b0;
    total++;
    if (dcount !== 0) begin
      bad++; $display("FAIL rst_no_done: got %0d dones want 0", dcount);
    end
    req = 4'b0011;
    serve(1'b0, b, g, d, ok);
    total++;
    if (!ok || b !== 8'h10 || g !== 4'b0001) begin
      bad++; $display("FAIL rst_ptr: got %h gnt=%b want 10 0001", b, g);
    end
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_lock_burst();
    test_level_done();
    test_watchdog();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
